// File: rtl/pix2byte_rgb888_gearbox_2lane.sv
// ---------------------------------------------------------------------------
// pix2byte_rgb888_gearbox_2lane
//
// 24->16 bit gearbox on the byte clock. Repacks a line of RGB888 pixels into
// the CSI-2 byte stream B,G,R,B,G,R,... with even stream bytes on lane 0
// (byte_data[7:0]) and odd stream bytes on lane 1 (byte_data[15:8]). Two
// pixels become three words. A line with an odd pixel count ends with a word
// whose lane-1 byte is PAD_BYTE (byte_half=1). The line byte count is
// reported on line_bytes alongside the last word of the line.
//
// Ports
//   CLKI        byte clock
//   RST         synchronous active-high reset
//   pix_data    pixel, [7:0]=B [15:8]=G [23:16]=R
//   pix_valid   pixel present
//   pix_sol     first pixel of a line
//   pix_eol     last pixel of a line
//   pix_ready   pixel accepted when pix_valid && pix_ready
//   byte_data   [7:0]=lane0 byte, [15:8]=lane1 byte
//   byte_valid  word present
//   byte_ready  word consumed when byte_valid && byte_ready
//   byte_sol    first word of a line
//   byte_eol    last word of a line
//   byte_half   lane-1 byte of the last word is pad
//   line_bytes  byte count of the line, valid with byte_eol
//   err         sticky protocol error, cleared only by RST
// ---------------------------------------------------------------------------
module pix2byte_rgb888_gearbox_2lane #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         WC_W     = 16
) (
    input  logic            CLKI,
    input  logic            RST,
    input  logic [23:0]     pix_data,
    input  logic            pix_valid,
    input  logic            pix_sol,
    input  logic            pix_eol,
    output logic            pix_ready,
    output logic [15:0]     byte_data,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            byte_sol,
    output logic            byte_eol,
    output logic            byte_half,
    output logic [WC_W-1:0] line_bytes,
    output logic            err
);

    typedef enum logic [1:0] {
        PH0   = 2'd0,  // aligned, next pixel starts a fresh word
        PH1   = 2'd1,  // one R byte left over from the previous pixel
        FLUSH = 2'd2,  // two bytes {R,G} left over, emit them
        PAD   = 2'd3   // odd-pixel line ended, emit R plus pad byte
    } state_t;

    state_t          state;
    logic [15:0]     residue;    // [7:0] used in PH1/PAD, [15:0]={R,G} in FLUSH
    logic            eol_carry;  // FLUSH word closes the line
    logic            in_line;    // sol seen since the last eol or reset
    logic [WC_W-1:0] byte_cnt;

    logic [7:0] pix_b, pix_g, pix_r;
    assign pix_b = pix_data[7:0];
    assign pix_g = pix_data[15:8];
    assign pix_r = pix_data[23:16];

    // Output register may load when empty or being drained this cycle.
    logic adv;
    logic accept;
    logic sol_err;   // sol arriving mid-pair: drop residue, restart as PH0
    logic take_ph0;  // pixel goes through the PH0 path

    assign adv       = !byte_valid || byte_ready;
    assign pix_ready = !RST && adv && (state == PH0 || state == PH1);
    assign accept    = pix_valid && pix_ready;
    assign sol_err   = accept && (state == PH1) && pix_sol;
    assign take_ph0  = accept && ((state == PH0) || sol_err);

    // Saturating byte counter next value.
    logic [WC_W:0]   cnt_sum;
    logic [WC_W-1:0] cnt_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cnt_next = byte_cnt;
        cnt_sum  = {1'b0, byte_cnt} + (WC_W+1)'(3);
        if (pix_sol)
            cnt_next = WC_W'(3);
        else if (cnt_sum[WC_W])
            cnt_next = '1;
        else
            cnt_next = cnt_sum[WC_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            state      <= PH0;
            residue    <= '0;
            eol_carry  <= 1'b0;
            in_line    <= 1'b0;
            byte_cnt   <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_sol   <= 1'b0;
            byte_eol   <= 1'b0;
            byte_half  <= 1'b0;
            line_bytes <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt <= cnt_next;
                in_line  <= (pix_sol || in_line) && !pix_eol;
                if (sol_err || (!pix_sol && !in_line))
                    err <= 1'b1;
            end

            if (adv) begin
                byte_valid <= 1'b0;
                byte_sol   <= 1'b0;
                byte_eol   <= 1'b0;
                byte_half  <= 1'b0;

                unique case (state)
                    PH0, PH1: begin
                        if (take_ph0) begin
                            byte_data  <= {pix_g, pix_b};
                            byte_valid <= 1'b1;
                            byte_sol   <= pix_sol;
                            residue    <= {8'h00, pix_r};
                            state      <= pix_eol ? PAD : PH1;
                        end else if (accept) begin
                            byte_data  <= {pix_b, residue[7:0]};
                            byte_valid <= 1'b1;
                            residue    <= {pix_r, pix_g};
                            eol_carry  <= pix_eol;
                            state      <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        byte_data  <= residue;
                        byte_valid <= 1'b1;
                        byte_eol   <= eol_carry;
                        if (eol_carry)
                            line_bytes <= byte_cnt;
                        state      <= PH0;
                    end
                    PAD: begin
                        byte_data  <= {PAD_BYTE, residue[7:0]};
                        byte_valid <= 1'b1;
                        byte_eol   <= 1'b1;
                        byte_half  <= 1'b1;
                        line_bytes <= byte_cnt;
                        state      <= PH0;
                    end
                    default: state <= PH0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pix2byte_rgb888_gearbox_2lane.sv
module tb_pix2byte_rgb888_gearbox_2lane;

    localparam int WC_W = 16;

    logic            CLKI = 1'b0;
    logic            RST;
    logic [23:0]     pix_data;
    logic            pix_valid, pix_sol, pix_eol, pix_ready;
    logic [15:0]     byte_data;
    logic            byte_valid, byte_ready, byte_sol, byte_eol, byte_half;
    logic [WC_W-1:0] line_bytes;
    logic            err;

    pix2byte_rgb888_gearbox_2lane #(.PAD_BYTE(8'h00), .WC_W(WC_W)) dut (
        .CLKI       (CLKI),
        .RST        (RST),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sol    (pix_sol),
        .pix_eol    (pix_eol),
        .pix_ready  (pix_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_sol   (byte_sol),
        .byte_eol   (byte_eol),
        .byte_half  (byte_half),
        .line_bytes (line_bytes),
        .err        (err)
    );

    always #5 CLKI = ~CLKI;

    typedef struct {
        logic [15:0] data;
        logic        sol;
        logic        eol;
        logic        half;
        logic [15:0] lb;
    } word_t;

    typedef struct {
        logic [23:0] pix;
        logic        sol;
        logic        eol;
        int          waits;   // cycles pix_ready stays low before accept
        word_t       w0;
        logic        has_w1;
        word_t       w1;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    word_t sb[$];
    vec_t  vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input logic [15:0] d, input logic s, input logic e,
                                 input logic h, input logic [15:0] lb);
        word_t w;
        w.data = d; w.sol = s; w.eol = e; w.half = h; w.lb = lb;
        return w;
    endfunction

    // Scoreboard: compare every consumed word with the head of the queue.
    always @(negedge CLKI) begin
        if (byte_valid && byte_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got word %0h want none", byte_data);
            end else begin
                word_t w;
                w = sb.pop_front();
                check("word_data", byte_data, w.data);
                check("word_sol",  byte_sol,  w.sol);
                check("word_eol",  byte_eol,  w.eol);
                check("word_half", byte_half, w.half);
                if (w.eol)
                    check("line_bytes", line_bytes, w.lb);
            end
        end
    end

    // Hold a pixel until accepted; counts cycles spent waiting.
    task automatic send_pix(input logic [23:0] d, input logic s, input logic e, output int waits);
        bit done;
        pix_data  = d;
        pix_sol   = s;
        pix_eol   = e;
        pix_valid = 1'b1;
        waits     = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge CLKI);
            if (pix_ready) done = 1'b1;
            else begin
                waits++;
                if (waits > 20) begin
                    $display("FAIL pix_accept: got no accept want accept within 20 cycles");
                    total++;
                    bad++;
                    pix_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge CLKI);
        #1;
    endtask

    task automatic run_vec(input int i);
        int w;
        sb.push_back(vecs[i].w0);
        if (vecs[i].has_w1) sb.push_back(vecs[i].w1);
        send_pix(vecs[i].pix, vecs[i].sol, vecs[i].eol, w);
        check($sformatf("pix_wait[%0d]", i), w, vecs[i].waits);
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge CLKI);
            #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic push_pix(input logic [23:0] d, input logic s, input logic e,
                            input word_t w0, input logic two, input word_t w1);
        int w;
        sb.push_back(w0);
        if (two) sb.push_back(w1);
        send_pix(d, s, e, w);
    endtask

    initial begin
        // Line 1: two pixels. Line 2: one pixel (sol+eol). Line 3: three pixels.
        vecs[0] = '{24'h332211, 1, 0, 0, mk(16'h2211, 1, 0, 0, 0), 0, mk(0, 0, 0, 0, 0)};
        vecs[1] = '{24'h665544, 0, 1, 0, mk(16'h4433, 0, 0, 0, 0), 1, mk(16'h6655, 0, 1, 0, 6)};
        vecs[2] = '{24'hCCBBAA, 1, 1, 1, mk(16'hBBAA, 1, 0, 0, 0), 1, mk(16'h00CC, 0, 1, 1, 3)};
        vecs[3] = '{24'h030201, 1, 0, 1, mk(16'h0201, 1, 0, 0, 0), 0, mk(0, 0, 0, 0, 0)};
        vecs[4] = '{24'h060504, 0, 0, 0, mk(16'h0403, 0, 0, 0, 0), 1, mk(16'h0605, 0, 0, 0, 0)};
        vecs[5] = '{24'h090807, 0, 1, 1, mk(16'h0807, 0, 0, 0, 0), 1, mk(16'h0009, 0, 1, 1, 9)};

        RST = 1'b1; pix_data = '0; pix_valid = 1'b0; pix_sol = 1'b0; pix_eol = 1'b0;
        byte_ready = 1'b1;
        repeat (3) @(posedge CLKI);
        #1;
        pix_valid = 1'b1;
        @(negedge CLKI);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_pix_ready",  pix_ready,  0);
        check("rst_err",        err,        0);
        check("rst_line_bytes", line_bytes, 0);
        check("rst_byte_data",  byte_data,  0);
        @(posedge CLKI);
        #1;
        pix_valid = 1'b0;
        RST = 1'b0;

        // Continuous pix_valid across three lines.
        for (int i = 0; i < 6; i++) run_vec(i);
        drain();
        check("err_clean", err, 0);

        // Stall byte_ready for 4 cycles mid-line.
        run_vec(0);
        byte_ready = 1'b0;
        pix_data = vecs[1].pix; pix_sol = 1'b0; pix_eol = 1'b1; pix_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLKI);
            check("stall_pix_ready", pix_ready,  0);
            check("stall_valid",     byte_valid, 1);
            check("stall_data",      byte_data,  16'h2211);
            check("stall_sol",       byte_sol,   1);
        end
        @(posedge CLKI);
        #1;
        byte_ready = 1'b1;
        run_vec(1);
        drain();

        // sol arriving in PH1: residue dropped, error sticky.
        push_pix(24'h0A0B0C, 1, 0, mk(16'h0B0C, 1, 0, 0, 0), 0, mk(0, 0, 0, 0, 0));
        push_pix(24'h112233, 1, 0, mk(16'h2233, 1, 0, 0, 0), 0, mk(0, 0, 0, 0, 0));
        push_pix(24'h445566, 0, 1, mk(16'h6611, 0, 0, 0, 0), 1, mk(16'h4455, 0, 1, 0, 6));
        drain();
        check("err_set", err, 1);
        repeat (3) @(posedge CLKI);
        #1;
        check("err_sticky", err, 1);

        // Reset one cycle after the first pixel of a line.
        push_pix(24'h332211, 1, 0, mk(16'h2211, 1, 0, 0, 0), 0, mk(0, 0, 0, 0, 0));
        pix_valid = 1'b0;
        RST = 1'b1;
        @(negedge CLKI);
        check("rst_mid_pix_ready", pix_ready, 0);
        @(posedge CLKI);
        #1;
        RST = 1'b0;
        @(negedge CLKI);
        check("rst_mid_valid", byte_valid, 0);
        check("rst_mid_err",   err,        0);
        check("rst_mid_lb",    line_bytes, 0);
        @(posedge CLKI);
        #1;
        run_vec(0);
        run_vec(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pix2byte_rgb888_gearbox_2lane.md
Name: pix2byte_rgb888_gearbox_2lane

Overview:
- Single-clock 24→16 gearbox on the byte clock (CLKOP domain of the pix2byte PLL).
- Converts a line of RGB888 pixels into CSI-2 byte order: B,G,R per pixel, with even stream bytes on lane 0 and odd stream bytes on lane 1.
- Feeds the 2-lane CSI-2 packetizer. Reports the line byte count (word count) with the last word.

Parameters:
- PAD_BYTE, 8'h00, value driven in the unused lane-1 byte of an odd-pixel line's final word.
- WC_W, 16, width of the line byte counter; saturates at all-ones.

Ports:
- CLKI  in  1  byte clock.
- RST  in  1  synchronous, active-high reset.
- pix_data  in  24  [7:0]=B, [15:8]=G, [23:16]=R.
- pix_valid  in  1  pixel present.
- pix_sol  in  1  qualifies first pixel of a line.
- pix_eol  in  1  qualifies last pixel of a line.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- byte_data  out  16  [7:0]=lane0 byte, [15:8]=lane1 byte.
- byte_valid  out  1  word present.
- byte_ready  in  1  word consumed when byte_valid && byte_ready.
- byte_sol  out  1  first word of line, qualified by byte_valid.
- byte_eol  out  1  last word of line, qualified by byte_valid.
- byte_half  out  1  last word's lane-1 byte is pad; valid with byte_eol.
- line_bytes  out  WC_W  byte count of the line, 3*N pixels; valid with byte_eol.
- err  out  1  sticky protocol error; cleared only by RST.

Behaviour:
- Reset: all outputs 0, pix_ready 0 during RST. State PH0, residue cleared, byte counter 0.
- Output register: loads when !byte_valid || byte_ready (adv). Holds data and flags stable while byte_valid && !byte_ready.
- Latency: 1 cycle from accepted pixel to byte_valid.
- pix_ready = adv && state ∈ {PH0, PH1}. Combinational from byte_ready.
- PH0, pixel P accepted:
  - Emit {P.G, P.B}; residue ← P.R.
  - Non-EOL pixel → PH1. EOL pixel → PAD.
- PH1, pixel Q accepted:
  - Emit {Q.B, residue}; residue ← {Q.R, Q.G}.
  - → FLUSH. Carries the EOL flag if Q is EOL.
- FLUSH (no input accepted): on adv, emit {res.R, res.G}; → PH0. byte_eol=1 if the carried EOL is set.
- PAD (no input accepted): on adv, emit {PAD_BYTE, residue}; byte_eol=1, byte_half=1; → PH0.
- byte_sol: set on the word produced from a pix_sol pixel.
- Pixel with both pix_sol and pix_eol is a 1-pixel line: 2 words, line_bytes=3.
- Byte counter:
  - +3 per accepted pixel.
  - Reset to 3 on a pix_sol pixel.
  - Saturates at 2^WC_W−1.
  - line_bytes is registered alongside the eol word.
- Protocol errors (each sets err):
  - pix_sol accepted in PH1: residue discarded, no word emitted for it, pixel processed as PH0.
  - Pixel accepted with no preceding sol since the last eol or reset: processed normally.
- RST mid-line: residue, state and pending output discarded immediately. byte_valid=0 next cycle.

Test Plan:
- 2-pixel line, P0=0x332211 (sol), P1=0x665544 (eol), byte_ready=1 → words 0x2211(sol), 0x4433, 0x6655(eol); line_bytes=6; byte_half=0.
- 1-pixel line 0xCCBBAA (sol+eol) → 0xBBAA(sol), 0x00CC(eol, half=1); line_bytes=3; pix_ready low during the PAD cycle.
- 3-pixel line with continuous pix_valid → 5 words, last has eol+half, line_bytes=9. pix_ready low exactly one cycle (FLUSH) after the 2nd pixel.
- byte_ready held low 4 cycles mid-line → byte_data and flags stable, pix_ready=0, no pixel lost or duplicated. Stream matches the no-stall result.
- sol asserted on the 2nd pixel of a line (PH1) → err=1 sticky; residue dropped; next word is {G,B} of the new pixel with byte_sol=1.
- RST pulsed one cycle after the 1st pixel of a line → byte_valid=0, err=0, line_bytes=0. A following 2-pixel line reproduces scenario 1 exactly.
